// File: rtl/ram8_gate.sv
// ram8_gate: eight 16-bit registers with per-register dirty flags and a
// self-timed 8-cycle clear sweep that blocks loads and further clears.
module dmux8way_gate (
    input  logic       in_i,
    input  logic [2:0] sel_i,
    output logic [7:0] out_o
);
    assign out_o = {7'b0, in_i} << sel_i;
endmodule

module ram8_gate (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [2:0]  address,
    input  logic        clr,
    output logic [15:0] out,
    output logic        busy,
    output logic [7:0]  dirty
);
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [15:0] r_q [8];
    logic [15:0] r_d [8];
    logic [7:0]  dirty_q, dirty_d;
    logic [7:0]  we;
    dmux8way_gate u_dmux (
        .in_i  (load && state_q == IDLE),
        .sel_i (address),
        .out_o (we)
    );
    assign out   = r_q[address];
    assign busy  = state_q == SWEEP;
    assign dirty = dirty_q;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        r_d     = r_q;
        dirty_d = dirty_q;
        if (state_q == IDLE) begin
            for (int k = 0; k < 8; k++) begin
                if (we[k]) begin
                    r_d[k]     = in;
                    dirty_d[k] = 1'b1;
                end
            end
            if (clr) begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        end else begin
            // Clearing R7 is the last sweep edge; clr/load are not looked at here.
            r_d[ptr_q]     = '0;
            dirty_d[ptr_q] = 1'b0;
            ptr_d          = ptr_q + 3'd1;
            if (ptr_q == 3'd7) state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            dirty_q <= '0;
            for (int k = 0; k < 8; k++) r_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dirty_q <= dirty_d;
            r_q     <= r_d;
        end
    end
endmodule

// File: doc/ram8_gate.md
RAM8_GATE -- requirements
Module: ram8_gate

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in, input, 16 bits: write data.
REQ-004 SHALL have port load, input, 1 bit: write request for the register selected by address.
REQ-005 SHALL have port address, input, 3 bits: register select for read and write.
REQ-006 SHALL have port clr, input, 1 bit: request to start a clear sweep.
REQ-007 SHALL have port out, output, 16 bits: contents of the register selected by address.
REQ-008 SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.
REQ-009 SHALL have port dirty, output, 8 bits: bit k high means R[k] was written since its last clear.

Function
REQ-010 SHALL hold eight 16-bit registers R0..R7.
REQ-011 SHALL route load to exactly one register by one-hot decode of address (a dmux8way_gate instance), with R[address] <= in on the rising edge when load=1 and FSM=IDLE.
REQ-012 SHALL set dirty[address] on every accepted write, including writes of 0 and rewrites of an already dirty register.
REQ-013 SHALL drive out = R[address] combinationally, with zero latency on address change.
REQ-014 SHALL give read-during-write old-data behaviour: the written value appears on out after the write edge.
REQ-015 SHALL implement FSM states IDLE and SWEEP plus a 3-bit sweep pointer ptr.
REQ-016 SHALL move IDLE -> SWEEP on an edge with clr=1, loading ptr=0.
REQ-017 SHALL, on each edge in SWEEP, set R[ptr]=0 and dirty[ptr]=0, then increment ptr.
REQ-018 SHALL move SWEEP -> IDLE on the edge that clears R7, so one sweep lasts exactly 8 cycles with busy high for exactly those 8 cycles.
REQ-019 SHALL drive busy=1 if and only if FSM=SWEEP, as a registered output.
REQ-020 SHALL ignore load while busy=1: no register change and no dirty change.
REQ-021 SHALL ignore clr while busy=1: no restart and no extension of the sweep.
REQ-022 SHALL, when load=1 and clr=1 on the same edge in IDLE, perform the write and enter SWEEP; the sweep later zeroes that register and clears its dirty bit.
REQ-023 SHALL keep out tracking live contents during a sweep: a register already swept reads 0, and one not yet swept reads its old value.
REQ-024 SHALL not create a new sweep from a clr held high across the SWEEP -> IDLE edge; a further sweep starts only on a later edge in IDLE with clr=1.

Reset
REQ-025 SHALL, while rst_n=0, force R0..R7=0, dirty=8'h00, FSM=IDLE, ptr=0 and busy=0 immediately, without waiting for a clock edge.
REQ-026 SHALL, if rst_n is asserted mid-sweep, abort the sweep and return to IDLE with all state cleared.
REQ-027 SHALL accept operations on the first rising edge after rst_n deasserts.
REQ-028 SHALL drive out=16'h0000 during reset for every address value.

Verification
REQ-029 Write/read: write 16'hA5A5 to addr 3, then 16'h1234 to addr 6 -> out=A5A5 at addr 3, 1234 at addr 6, 0 elsewhere; dirty=8'h48.
REQ-030 Read-during-write: address=2 holding 16'h0011, load=1, in=16'h0022 -> out=0011 before the edge and 0022 after it.
REQ-031 Sweep: fill all 8 registers, pulse clr for 1 cycle -> busy high for exactly 8 cycles; R[k] reads 0 from the (k+1)th sweep edge; dirty=8'h00 at the end.
REQ-032 Ignored inputs: during a sweep, drive load=1 to addr 7 with 16'hFFFF and re-pulse clr -> R7=0, dirty[7]=0, busy drops after the original 8 cycles.
REQ-033 Simultaneous: load=1 at addr 0 with 16'hBEEF and clr=1 on the same IDLE edge -> out(addr 0)=BEEF and dirty[0]=1 for one cycle, then 0 and 0 after the first sweep edge.
REQ-034 Reset mid-sweep: assert rst_n=0 at sweep cycle 4 between edges -> busy=0, dirty=0 and all registers read 0 immediately; a write after release behaves as REQ-029.
